regfile_wport_arb: RTL and testbench

//  Shares the register file's single write port (c_we/csel/din) among NREQ writeback requesters
//  (ALU, load unit, trap/CSR sequencer). Round-robin arbitration, optional bus lock for multi-write

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_wport_arb_rr_pick.sv | 37 +++
 rtl/regfile_wport_arb.sv | 152 +++++++++++++++
 tb/tb_regfile_wport_arb.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file definitions for the write-port arbiter: register indices,
// the register-select type, the arbiter state encoding and a wrap-around increment.
package regfile_pkg;

    typedef logic [4:0] regsel_t;

    localparam regsel_t REG_ZERO = 5'h00;
    localparam regsel_t REG_SR   = 5'h01;
    localparam regsel_t REG_PC   = 5'h02;
    localparam regsel_t REG_IR   = 5'h03;
    localparam regsel_t REG_LR   = 5'h1d;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    function automatic int unsigned wrapInc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_wport_arb_rr_pick.sv
// Combinational round-robin select: first set bit of the eligible mask at or after ptr,
// wrapping from NREQ-1 back to 0. Produces a one-hot grant and its encoded index.
module rr_pick
    import regfile_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]         elig_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         grant_o,
    output logic [$clog2(NREQ)-1:0] idx_o,
    output logic                    any_o
);
    localparam int IW = $clog2(NREQ);

    logic [IW:0] cand;

    // Walk candidates in priority order starting at ptr; the first eligible one wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_i} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!any_o && elig_i[cand[IW-1:0]]) begin
                any_o = 1'b1;
                idx_o = cand[IW-1:0];
            end
        end
        grant_o = any_o ? (NREQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/regfile_wport_arb.sv
// Register-file write-port arbiter: round-robin among NREQ writeback requesters with bus lock
// and r29/ir_tsf collision stall. Optional grant counters under REGFILE_ARB_STATS_EN.
module regfile_wport_arb
    import regfile_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_lock,
    input  logic [NREQ*5-1:0]        req_sel,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     ir_tsf,
    output logic                     c_we,
    output logic [4:0]               csel,
    output logic [DW-1:0]            din,
    output logic [$clog2(NREQ)-1:0]  lock_owner,
    output logic                     locked
`ifdef REGFILE_ARB_STATS_EN
    ,
    input  logic                     stats_clr,
    output logic [NREQ*16-1:0]       grant_cnt
`endif
);
    localparam int IW = $clog2(NREQ);

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic            we_q;
    regsel_t         sel_q;
    logic [DW-1:0]   data_q;

    logic [NREQ-1:0] lrFree;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grantIdx;
    logic            grantAny;
    regsel_t         grantSel;
    logic [DW-1:0]   grantData;

    // A write to r29 collides with the pc transfer, so it waits; others are unaffected.
    always_comb begin
        lrFree = '0;
        elig   = '0;
        for (int i = 0; i < NREQ; i++) begin
            lrFree[i] = !(ir_tsf && (req_sel[5*i +: 5] == REG_LR));
        end
        if (!rst_n) begin
            elig = '0;
        end else if (state_q == ARB_IDLE) begin
            elig = req_valid & lrFree;
        end else begin
            elig[owner_q] = req_valid[owner_q] & lrFree[owner_q];
        end
    end

    rr_pick #(.NREQ(NREQ)) u_pick (
        .elig_i  (elig),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (grantIdx),
        .any_o   (grantAny)
    );

    assign req_ready = grant;
    assign grantSel  = req_sel[5*grantIdx +: 5];
    assign grantData = req_data[DW*grantIdx +: DW];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            ARB_IDLE: begin
                if (grantAny) begin
                    ptr_d = IW'(wrapInc(32'(grantIdx), NREQ));
                    if (req_lock[grantIdx]) begin
                        state_d = ARB_LOCKED;
                        owner_d = grantIdx;
                    end
                end
            end
            ARB_LOCKED: begin
                // ptr stays frozen while locked; an owner that drops valid abandons the lock.
                if (grantAny) begin
                    if (!req_lock[grantIdx]) begin
                        state_d = ARB_IDLE;
                        ptr_d   = IW'(wrapInc(32'(owner_q), NREQ));
                    end
                end else if (!req_valid[owner_q]) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // r0 beats are accepted and consume the grant but never raise the write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            we_q    <= 1'b0;
            sel_q   <= REG_ZERO;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            we_q    <= grantAny && (grantSel != REG_ZERO);
            if (grantAny) begin
                sel_q  <= grantSel;
                data_q <= grantData;
            end
        end
    end

    assign c_we       = we_q;
    assign csel       = sel_q;
    assign din        = data_q;
    assign lock_owner = owner_q;
    assign locked     = (state_q == ARB_LOCKED);

`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] cnt_q [NREQ];

    // Clear has priority over a same-cycle grant; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREQ; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (stats_clr) begin
                    cnt_q[k] <= '0;
                end else if (grant[k] && (cnt_q[k] != 16'hFFFF)) begin
                    cnt_q[k] <= cnt_q[k] + 16'd1;
                end
            end
        end
    end

    for (genvar k = 0; k < NREQ; k++) begin : g_cnt
        assign grant_cnt[16*k +: 16] = cnt_q[k];
    end
`endif

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Scoreboard bench for regfile_wport_arb: a spec-level model predicts grants and writes;
// a separate monitor checks every registered write. Covers REGFILE_ARB_STATS_EN when defined.
module tb_regfile_wport_arb;

    localparam int NREQ = 3;
    localparam int DW   = 32;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_lock;
    logic [14:0] req_sel;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        ir_tsf;
    logic        c_we;
    logic [4:0]  csel;
    logic [31:0] din;
    logic [1:0]  lock_owner;
    logic        locked;
`ifdef REGFILE_ARB_STATS_EN
    logic        stats_clr;
    logic [47:0] grant_cnt;
`endif

    regfile_wport_arb #(.NREQ(NREQ), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_lock   (req_lock),
        .req_sel    (req_sel),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .ir_tsf     (ir_tsf),
        .c_we       (c_we),
        .csel       (csel),
        .din        (din),
        .lock_owner (lock_owner),
        .locked     (locked)
`ifdef REGFILE_ARB_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .grant_cnt  (grant_cnt)
`endif
    );

    typedef struct {
        int          cyc;
        logic [4:0]  sel;
        logic [31:0] data;
    } wr_t;

    wr_t expQ[$];
    int  checks  = 0;
    int  errors  = 0;
    int  cycleNo = 0;

    bit  mLocked;
    int  mOwner;
    int  mPtr;
    int  mCnt[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleNo <= cycleNo + 1;

    task automatic checkVal(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", name, cycleNo, got, exp);
        end
    endtask

    task automatic modelReset();
        mLocked = 1'b0;
        mOwner  = 0;
        mPtr    = 0;
        for (int i = 0; i < 3; i++) mCnt[i] = 0;
        expQ.delete();
    endtask

    function automatic logic [14:0] packSel(input int a, input int b, input int c);
        return {5'(c), 5'(b), 5'(a)};
    endfunction

    task automatic applyStimulus(input logic [2:0] v, input logic [2:0] l, input logic [14:0] s,
                                 input logic [95:0] d, input logic t);
        req_valid = v;
        req_lock  = l;
        req_sel   = s;
        req_data  = d;
        ir_tsf    = t;
    endtask

    // Predict this cycle's grant from the arbitration rules, compare, then advance the model.
    task automatic checkOutput(output int g);
        logic [2:0] elig;
        logic [2:0] expReady;
        #1;
        g = -1;
        for (int i = 0; i < 3; i++) begin
            elig[i] = req_valid[i] && !(ir_tsf && (req_sel[5*i +: 5] == 5'd29));
        end
        if (mLocked) begin
            if (elig[mOwner]) g = mOwner;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (g < 0 && elig[(mPtr + k) % 3]) g = (mPtr + k) % 3;
            end
        end
        expReady = (g >= 0) ? 3'(1 << g) : 3'b000;
        checkVal("ready", 64'(req_ready), 64'(expReady));
        checkVal("locked", 64'(locked), 64'(mLocked));
        if (mLocked) checkVal("lock_owner", 64'(lock_owner), 64'(mOwner));
`ifdef REGFILE_ARB_STATS_EN
        for (int k = 0; k < 3; k++) checkVal("grant_cnt", 64'(grant_cnt[16*k +: 16]), 64'(mCnt[k]));
        if (stats_clr) begin
            for (int k = 0; k < 3; k++) mCnt[k] = 0;
        end else if (g >= 0 && mCnt[g] < 65535) begin
            mCnt[g]++;
        end
`endif
        if (mLocked) begin
            if (g >= 0) begin
                if (!req_lock[g]) begin
                    mLocked = 1'b0;
                    mPtr    = (mOwner + 1) % 3;
                end
            end else if (!req_valid[mOwner]) begin
                mLocked = 1'b0;
            end
        end else if (g >= 0) begin
            mPtr = (g + 1) % 3;
            if (req_lock[g]) begin
                mLocked = 1'b1;
                mOwner  = g;
            end
        end
        if (g >= 0 && req_sel[5*g +: 5] != 5'd0) begin
            expQ.push_back('{cycleNo + 1, req_sel[5*g +: 5], req_data[32*g +: 32]});
        end
    endtask

    task automatic runCycle(input logic [2:0] v, input logic [2:0] l, input logic [14:0] s,
                            input logic [95:0] d, input logic t, output int g);
        @(negedge clk);
        applyStimulus(v, l, s, d, t);
        checkOutput(g);
    endtask

    // Monitor: every cycle the write enable must match what the scoreboard has due.
    always @(posedge clk) begin : monitor
        bit due;
        #1;
        if (rst_n) begin
            due = (expQ.size() > 0) && (expQ[0].cyc == cycleNo);
            checkVal("c_we", 64'(c_we), 64'(due));
            if (due) begin
                if (c_we) begin
                    checkVal("csel", 64'(csel), 64'(expQ[0].sel));
                    checkVal("din", 64'(din), 64'(expQ[0].data));
                end
                void'(expQ.pop_front());
            end
        end
    end

    initial begin : stimulus
        int          g;
        bit          pend[3];
        logic [4:0]  pSel[3];
        logic [31:0] pData[3];
        bit          pLock[3];
        int          r;

        modelReset();
        rst_n = 1'b1;
        applyStimulus(3'b111, 3'b000, packSel(5, 6, 7), {32'h3, 32'h2, 32'h1}, 1'b0);
`ifdef REGFILE_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #4;
        checkVal("rst c_we", 64'(c_we), 64'(0));
        checkVal("rst csel", 64'(csel), 64'(0));
        checkVal("rst din", 64'(din), 64'(0));
        checkVal("rst req_ready", 64'(req_ready), 64'(0));
        checkVal("rst locked", 64'(locked), 64'(0));
        checkVal("rst lock_owner", 64'(lock_owner), 64'(0));
        @(negedge clk);
        applyStimulus(3'b000, 3'b000, '0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin over three always-valid requesters.
        for (int c = 0; c < 4; c++) begin
            runCycle(3'b111, 3'b000, packSel(5, 6, 7), {32'hC0DE0007, 32'hC0DE0006, 32'hC0DE0005}, 1'b0, g);
        end

        // r29 stalled by ir_tsf while another requester slips through.
        runCycle(3'b110, 3'b000, packSel(0, 29, 8), {32'h88, 32'h2929, 32'h0}, 1'b1, g);
        runCycle(3'b010, 3'b000, packSel(0, 29, 8), {32'h88, 32'h2929, 32'h0}, 1'b0, g);
        runCycle(3'b100, 3'b000, packSel(0, 0, 9), {32'h99, 32'h0, 32'h0}, 1'b0, g);

        // Three-beat locked sequence from requester 0 holds off requester 2.
        runCycle(3'b101, 3'b001, packSel(10, 0, 12), {32'hCC, 32'h0, 32'hA1}, 1'b0, g);
        runCycle(3'b101, 3'b001, packSel(11, 0, 12), {32'hCC, 32'h0, 32'hA2}, 1'b0, g);
        runCycle(3'b101, 3'b000, packSel(13, 0, 12), {32'hCC, 32'h0, 32'hA3}, 1'b0, g);
        runCycle(3'b100, 3'b000, packSel(0, 0, 12), {32'hCC, 32'h0, 32'h0}, 1'b0, g);

        // r0 sink beat, then confirm the pointer moved past requester 0.
        runCycle(3'b001, 3'b000, packSel(0, 0, 0), {32'h0, 32'h0, 32'hDEADBEEF}, 1'b0, g);
        runCycle(3'b111, 3'b000, packSel(1, 2, 3), {32'h33, 32'h22, 32'h11}, 1'b0, g);

        // Randomized traffic with r29/r0 bias, locks, abandoned locks and ir_tsf.
        for (int i = 0; i < 3; i++) pend[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 9) < 6) begin
                    pend[i] = 1'b1;
                    r = $urandom_range(0, 9);
                    pSel[i]  = (r < 2) ? 5'd29 : (r < 3) ? 5'd0 : 5'($urandom_range(1, 31));
                    pData[i] = $urandom;
                    pLock[i] = ($urandom_range(0, 3) == 0);
                end
            end
            runCycle({pend[2], pend[1], pend[0]}, {pLock[2], pLock[1], pLock[0]},
                     {pSel[2], pSel[1], pSel[0]}, {pData[2], pData[1], pData[0]},
                     1'($urandom_range(0, 2) == 0), g);
            if (g >= 0) pend[g] = 1'b0;
        end
        for (int c = 0; c < 3; c++) runCycle(3'b000, 3'b000, '0, '0, 1'b0, g);

        // Reset asserted just after a locking grant: write discarded, lock and ptr cleared.
        runCycle(3'b010, 3'b010, packSel(0, 14, 0), {32'h0, 32'h1414, 32'h0}, 1'b0, g);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkVal("async rst c_we", 64'(c_we), 64'(0));
        checkVal("async rst locked", 64'(locked), 64'(0));
        modelReset();
        applyStimulus(3'b000, 3'b000, '0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        runCycle(3'b111, 3'b000, packSel(15, 16, 17), {32'h17, 32'h16, 32'h15}, 1'b0, g);
        runCycle(3'b000, 3'b000, '0, '0, 1'b0, g);

`ifdef REGFILE_ARB_STATS_EN
        // Saturate requester 0's counter, then clear it while it is being granted.
        for (int c = 0; c < 70000; c++) begin
            runCycle(3'b001, 3'b000, packSel(5, 0, 0), {64'h0, 32'(c)}, 1'b0, g);
        end
        runCycle(3'b000, 3'b000, '0, '0, 1'b0, g);
        checkVal("sat cnt0", 64'(grant_cnt[15:0]), 64'hFFFF);
        @(negedge clk);
        stats_clr = 1'b1;
        applyStimulus(3'b001, 3'b000, packSel(6, 0, 0), {64'h0, 32'h66}, 1'b0);
        checkOutput(g);
        @(negedge clk);
        stats_clr = 1'b0;
        applyStimulus(3'b000, 3'b000, '0, '0, 1'b0);
        checkOutput(g);
        checkVal("clr cnt0", 64'(grant_cnt[15:0]), 64'(0));
`endif

        for (int c = 0; c < 3; c++) runCycle(3'b000, 3'b000, '0, '0, 1'b0, g);
        checkVal("scoreboard drained", 64'(expQ.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
